clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Measures a divided clock signal such as the 16.67 MHz output of the team's basys_clk dividers (a toggle every 3 basys_clk cycles). It is the receiving end of that divided-clock interface. The block synchronises the divided signal into the basys_clk domain and emits one-cycle rise and fall strobes for downstream logic. It also measures every half-period in basys_clk cycles and declares lock once the measurement has been stable for a programmable number of half-periods. It sits next to each clock divider as a clock-enable source and health monitor.

## Interface
- EXP_HALF, default 3: expected half-period in basys_clk cycles; must be ≥ 2.
- TOL, default 0: allowed absolute deviation from EXP_HALF.
- LOCK_COUNT, default 8: consecutive in-tolerance half-periods required to lock; must be ≥ 1.
- CNT_W, default 16: width of the period counter and of half_period.
- basys_clk  input  1  system clock, 100 MHz; sole clock.
- rst_n  input  1  reset; asynchronous assert, active-low. Applies to every flop, including the synchroniser.
- clk_in  input  1  divided clock to monitor; may be asynchronous to basys_clk.
- rise_pulse  output  1  one-cycle strobe per detected rising edge of clk_in.
- fall_pulse  output  1  one-cycle strobe per detected falling edge of clk_in.
- half_period  output  CNT_W  last measured half-period, in cycles.
- locked  output  1  measurement stable and in tolerance.
- err  output  1  one-cycle strobe on each tolerance violation or stall.
- err_count  output  8  saturating count of err strobes.

## Operation
- Synchroniser: two flops, s1 then s2. A third flop s3 holds the previous value of s2.
- Edge detect: an edge exists when s2 ≠ s3. rise_pulse ← s2 & ~s3 and fall_pulse ← ~s2 & s3, both registered.
- Period counter run_cnt (CNT_W bits):
  - Cleared to 0 on a detected edge; otherwise increments and saturates at all-ones.
  - On each edge, meas = run_cnt + 1 (saturating) is the number of cycles since the previous edge, and half_period ← meas.
- In tolerance: |meas − EXP_HALF| ≤ TOL. Compute with CNT_W+1-bit unsigned arithmetic; no wrap.
- FSM states: IDLE, ACQUIRE, LOCKED. A 2-bit state register.
  - IDLE: the first edge goes to ACQUIRE with good_cnt=0. That first interval is not checked and half_period is not updated, because the reset phase is arbitrary.
  - ACQUIRE:
    - In-tolerance edge: good_cnt+1. When good_cnt reaches LOCK_COUNT, go to LOCKED.
    - Out-of-tolerance edge: good_cnt←0, err strobe, stay in ACQUIRE.
  - LOCKED:
    - In-tolerance edge: stay.
    - Out-of-tolerance edge: go to ACQUIRE, good_cnt←0, err strobe.
  - Stall (from ACQUIRE or LOCKED): run_cnt reaches 2·EXP_HALF + TOL with no edge. Go to IDLE, good_cnt←0, one err strobe. No repeat strobes while stalled in IDLE.
- locked = (state == LOCKED), registered.
- err_count increments on each err and holds at 255.
- Simultaneous events: an edge in the same cycle as the stall threshold is treated as an edge, and the stall is not raised.
- Reset mid-operation clears all state immediately.
  - Reset values: s1/s2/s3=0, rise_pulse=0, fall_pulse=0, half_period=0, locked=0, err=0, err_count=0, run_cnt=0, good_cnt=0, state=IDLE.
  - After reset release with clk_in already high, one rising edge is detected. It is handled as the IDLE first edge.

## Timing
- clk_in changes before basys_clk edge k. s1 captures it at k, s2 at k+1, and rise_pulse/fall_pulse are high in the cycle after edge k+2. Latency is 3 cycles.
- half_period, the state change, and err update on the same edge that registers the rise/fall strobe.
- locked asserts on the edge that registers the LOCK_COUNT-th good measurement after the first edge.
- Pulse spacing equals the clk_in half-period. rise_pulse and fall_pulse are never high together.
- The stall err is issued on the edge where run_cnt reaches the threshold. locked falls on that same edge.

## Test plan
- Reset, then drive clk_in from a toggle-every-3-cycles divider with default parameters → one pulse every 3 cycles, rise and fall alternating. half_period=3. locked rises at the 9th detected edge. err_count=0.
- Locked, then a single half-period of 5 → one err strobe, locked=0, half_period=5, err_count=1. Relock after 8 further good half-periods.
- Locked, then hold clk_in constant → err strobe when run_cnt reaches 6, state IDLE, locked=0, exactly one err. On resumed toggling, relock after 1+8 edges.
- TOL=1 with half-periods alternating 2 and 4 → no err, locked after 9 edges. A half-period of 5 → err.
- Assert rst_n low mid-lock while clk_in toggles → all outputs 0 asynchronously. After release, err_count=0 and lock reacquires after 9 edges.
- Force 300 errors with alternating periods 3 and 7 → err_count saturates at 255.

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor
// Receives a divided clock (for example a basys_clk divider output) and
// brings it into the basys_clk domain. It produces one-cycle rise and fall
// strobes for downstream clock-enable use. It also measures every
// half-period and reports lock once the measurement has been stable for
// LOCK_COUNT consecutive half-periods.
//
// Parameters
//   EXP_HALF   expected half-period in basys_clk cycles (>= 2)
//   TOL        allowed absolute deviation from EXP_HALF
//   LOCK_COUNT consecutive good half-periods needed to lock (>= 1)
//   CNT_W      width of the period counter and half_period
//
// Ports
//   basys_clk    in   system clock, sole clock
//   rst_n        in   async active-low reset, clears every flop
//   clk_in       in   divided clock to monitor, may be asynchronous
//   rise_pulse   out  one-cycle strobe per rising edge of clk_in
//   fall_pulse   out  one-cycle strobe per falling edge of clk_in
//   half_period  out  last measured half-period, in cycles
//   locked       out  measurement stable and in tolerance
//   err          out  one-cycle strobe per tolerance violation or stall
//   err_count    out  saturating count of err strobes
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no reference edge yet (after reset or stall); no checking
// ACQUIRE | counting consecutive in-tolerance half-periods
// LOCKED  | LOCK_COUNT good half-periods seen, still in tolerance
module clk_div_monitor #(
   parameter int EXP_HALF   = 3,
   parameter int TOL        = 0,
   parameter int LOCK_COUNT = 8,
   parameter int CNT_W      = 16
) (
   input  logic             basys_clk,
   input  logic             rst_n,
   input  logic             clk_in,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] half_period,
   output logic             locked,
   output logic             err,
   output logic [7:0]       err_count
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W:0]   EXP_X    = (CNT_W+1)'(EXP_HALF);
   localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
   // Stall fires on the edge where run_cnt would become 2*EXP_HALF+TOL.
   localparam logic [CNT_W-1:0] STALL_M1 = CNT_W'(2*EXP_HALF + TOL - 1);
   localparam logic [GW-1:0]    LOCK_N   = GW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic             rise_q, rise_d, fall_q, fall_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] half_period_q, half_period_d;
   logic [GW-1:0]    good_cnt_q, good_cnt_d;
   logic             locked_q, locked_d;
   logic             err_q, err_d;
   logic [7:0]       err_count_q, err_count_d;

   logic             edge_det;
   logic             stall;
   logic             in_tol;
   logic [CNT_W-1:0] meas;
   logic [CNT_W:0]   meas_x;
   logic [CNT_W:0]   diff;
   logic [GW-1:0]    good_inc;

   always_comb begin
      edge_det = s2_q ^ s3_q;
      meas     = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);
      meas_x   = {1'b0, meas};
      diff     = (meas_x >= EXP_X) ? (meas_x - EXP_X) : (EXP_X - meas_x);
      in_tol   = (diff <= TOL_X);
      // An edge in the threshold cycle wins over the stall.
      stall    = !edge_det && (run_cnt_q == STALL_M1);
      good_inc = good_cnt_q + GW'(1);
   end

   always_comb begin
      s1_d          = clk_in;
      s2_d          = s1_q;
      s3_d          = s2_q;
      rise_d        = s2_q & ~s3_q;
      fall_d        = ~s2_q & s3_q;
      run_cnt_d     = edge_det ? '0 : meas;
      half_period_d = half_period_q;
      state_d       = state_q;
      good_cnt_d    = good_cnt_q;
      err_d         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The first interval after reset/stall has an arbitrary phase,
            // so it is neither checked nor reported.
            if (edge_det) begin
               state_d    = ST_ACQ;
               good_cnt_d = '0;
            end
         end
         ST_ACQ: begin
            if (edge_det) begin
               half_period_d = meas;
               if (in_tol) begin
                  good_cnt_d = good_inc;
                  if (good_inc == LOCK_N) state_d = ST_LOCK;
               end else begin
                  good_cnt_d = '0;
                  err_d      = 1'b1;
               end
            end else if (stall) begin
               state_d    = ST_IDLE;
               good_cnt_d = '0;
               err_d      = 1'b1;
            end
         end
         ST_LOCK: begin
            if (edge_det) begin
               half_period_d = meas;
               if (!in_tol) begin
                  state_d    = ST_ACQ;
                  good_cnt_d = '0;
                  err_d      = 1'b1;
               end
            end else if (stall) begin
               state_d    = ST_IDLE;
               good_cnt_d = '0;
               err_d      = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            good_cnt_d = '0;
         end
      endcase

      locked_d    = (state_d == ST_LOCK);
      err_count_d = (err_d && (err_count_q != 8'hFF)) ? err_count_q + 8'd1
                                                      : err_count_q;
   end

   always_ff @(posedge basys_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         s3_q          <= 1'b0;
         rise_q        <= 1'b0;
         fall_q        <= 1'b0;
         run_cnt_q     <= '0;
         half_period_q <= '0;
         good_cnt_q    <= '0;
         state_q       <= ST_IDLE;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
         err_count_q   <= 8'd0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         s3_q          <= s3_d;
         rise_q        <= rise_d;
         fall_q        <= fall_d;
         run_cnt_q     <= run_cnt_d;
         half_period_q <= half_period_d;
         good_cnt_q    <= good_cnt_d;
         state_q       <= state_d;
         locked_q      <= locked_d;
         err_q         <= err_d;
         err_count_q   <= err_count_d;
      end
   end

   assign rise_pulse  = rise_q;
   assign fall_pulse  = fall_q;
   assign half_period = half_period_q;
   assign locked      = locked_q;
   assign err         = err_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: table-driven half-period rows on a
// default instance, plus hand-written sequences for stall, reset, edge at
// the stall threshold, tolerance window (TOL=1 instance) and saturation.
module tb_clk_div_monitor;

   logic        basys_clk;
   logic        rst_n;
   logic        clk_in;
   logic        clk_in_t;

   logic        rise_pulse, fall_pulse, locked, err;
   logic [15:0] half_period;
   logic [7:0]  err_count;

   logic        rise_t, fall_t, locked_t, err_t;
   logic [15:0] half_t;
   logic [7:0]  errc_t;

   int errors = 0;
   int checks = 0;
   int overlap_cnt = 0;
   int err_seen = 0;
   int err_base;
   int cyc;

   clk_div_monitor dut (
      .basys_clk  (basys_clk),
      .rst_n      (rst_n),
      .clk_in     (clk_in),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .half_period(half_period),
      .locked     (locked),
      .err        (err),
      .err_count  (err_count)
   );

   clk_div_monitor #(.TOL(1)) dut_t (
      .basys_clk  (basys_clk),
      .rst_n      (rst_n),
      .clk_in     (clk_in_t),
      .rise_pulse (rise_t),
      .fall_pulse (fall_t),
      .half_period(half_t),
      .locked     (locked_t),
      .err        (err_t),
      .err_count  (errc_t)
   );

   initial basys_clk = 1'b0;
   always #5 basys_clk = ~basys_clk;

   always @(negedge basys_clk) begin
      if (rise_pulse && fall_pulse) overlap_cnt <= overlap_cnt + 1;
      if (err) err_seen <= err_seen + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int   hp;
      int   n;
      logic rise;
      logic fall;
      logic lk;
      int   half;
      int   errc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Toggle clk_in, then hold it for hp cycles; ends 1 time unit after a posedge.
   task automatic half(input int hp);
      clk_in = ~clk_in;
      repeat (hp) @(posedge basys_clk);
      #1;
   endtask

   task automatic half_tol(input int hp);
      clk_in_t = ~clk_in_t;
      repeat (hp) @(posedge basys_clk);
      #1;
   endtask

   initial begin
      // Each row's edge measures the previous row's hold time.
      //           hp n  rise fall lk half errc
      vecs[0] = '{3, 8, 1'b0, 1'b1, 1'b0, 3, 0};  // edges 1..8: not yet locked
      vecs[1] = '{3, 1, 1'b1, 1'b0, 1'b1, 3, 0};  // 9th edge locks
      vecs[2] = '{5, 1, 1'b0, 1'b0, 1'b1, 3, 0};  // start a 5-cycle half-period
      vecs[3] = '{3, 1, 1'b1, 1'b0, 1'b0, 5, 1};  // measured 5 -> err, unlock
      vecs[4] = '{3, 7, 1'b0, 1'b1, 1'b0, 3, 1};  // 7 good, not yet relocked
      vecs[5] = '{3, 1, 1'b1, 1'b0, 1'b1, 3, 1};  // 8th good relocks

      rst_n    = 1'b0;
      clk_in   = 1'b0;
      clk_in_t = 1'b0;
      repeat (3) @(posedge basys_clk);
      #1;
      chk("rst_rise",   rise_pulse,  0);
      chk("rst_fall",   fall_pulse,  0);
      chk("rst_half",   half_period, 0);
      chk("rst_locked", locked,      0);
      chk("rst_err",    err,         0);
      chk("rst_errc",   err_count,   0);
      rst_n = 1'b1;
      repeat (2) @(posedge basys_clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < vecs[i].n; j++) half(vecs[i].hp);
         chk($sformatf("v%0d_rise", i),   rise_pulse,  vecs[i].rise);
         chk($sformatf("v%0d_fall", i),   fall_pulse,  vecs[i].fall);
         chk($sformatf("v%0d_locked", i), locked,      vecs[i].lk);
         chk($sformatf("v%0d_half", i),   half_period, vecs[i].half);
         chk($sformatf("v%0d_errc", i),   err_count,   vecs[i].errc);
      end

      // Stall: hold clk_in while locked; err expected when run_cnt reaches 6.
      cyc = 0;
      while (err !== 1'b1 && cyc < 20) begin
         @(posedge basys_clk);
         #1;
         cyc++;
      end
      chk("stall_cycles", cyc,       6);
      chk("stall_locked", locked,    0);
      chk("stall_errc",   err_count, 2);
      repeat (20) @(posedge basys_clk);
      #1;
      chk("stall_no_repeat", err_count, 2);
      chk("stall_err_seen",  err_seen,  2);
      chk("stall_half_held", half_period, 3);

      // Resume: first edge only restarts acquisition, then 8 good lock.
      repeat (8) half(3);
      chk("resume_not_locked", locked, 0);
      half(3);
      chk("resume_locked", locked, 1);
      chk("resume_errc", err_count, 2);

      // Async reset mid-lock while clk_in keeps toggling.
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_rise",   rise_pulse,  0);
      chk("arst_fall",   fall_pulse,  0);
      chk("arst_half",   half_period, 0);
      chk("arst_locked", locked,      0);
      chk("arst_err",    err,         0);
      chk("arst_errc",   err_count,   0);
      repeat (3) begin
         clk_in = ~clk_in;
         repeat (2) @(posedge basys_clk);
      end
      clk_in = 1'b1;
      @(posedge basys_clk);
      #1;
      rst_n = 1'b1;
      // clk_in already high at release: one rising edge, 3 cycles later.
      repeat (3) @(posedge basys_clk);
      #1;
      chk("rel_rise",   rise_pulse, 1);
      chk("rel_locked", locked,     0);
      repeat (7) half(3);
      chk("rel_not_locked", locked, 0);
      half(3);
      chk("rel_locked9", locked, 1);
      chk("rel_errc",    err_count, 0);

      // Edge in the same cycle as the stall threshold: treated as an edge
      // (half_period updated to 6, one err, ACQUIRE rather than IDLE).
      half(6);
      half(3);
      chk("thr_half",   half_period, 6);
      chk("thr_errc",   err_count,   1);
      chk("thr_locked", locked,      0);
      repeat (7) half(3);
      chk("thr_not_locked", locked, 0);
      half(3);
      chk("thr_relock", locked, 1);

      // TOL=1 instance: half-periods alternating 4 and 2 stay in tolerance.
      for (int i = 0; i < 8; i++) half_tol((i % 2 == 0) ? 4 : 2);
      chk("tol_not_locked", locked_t, 0);
      half_tol(4);
      chk("tol_locked", locked_t, 1);
      chk("tol_half",   half_t,   2);
      chk("tol_errc",   errc_t,   0);
      half_tol(5);
      half_tol(4);
      chk("tol5_errc",   errc_t,   1);
      chk("tol5_locked", locked_t, 0);
      chk("tol5_half",   half_t,   5);

      // Saturation: each 3/7 pair produces exactly one stall err.
      err_base = err_seen;
      for (int i = 0; i < 300; i++) begin
         half(3);
         half(7);
      end
      repeat (5) @(posedge basys_clk);
      #1;
      chk("sat_err_strobes", err_seen - err_base, 300);
      chk("sat_errc", err_count, 255);

      chk("no_rise_fall_overlap", overlap_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
